bf_tape_arbiter: RTL

- Owns the single-port tape (data) RAM and shares it between the execution FSM ("core") and the display/debug viewer ("dbg").
- Also contains an internal clear engine that zeroes every tape cell after reset or on request.
- Sits between the control FSM's datapath enables and the tape RAM instance.
- Guarantees one RAM access per cycle, fixed priority, no lost requests.

---
 rtl/bf_pkg.sv | 17 +
 rtl/bf_tape_arbiter_if.sv | 60 ++++++
 rtl/bf_tape_clear_seq.sv | 43 ++++
 rtl/bf_tape_arbiter.sv | 139 +++++++++++++
 4 files changed

// File: rtl/bf_pkg.sv
// -----------------------------------------------------------------------------
// bf_pkg
// Shared definitions for the tape datapath: the arbiter state encoding and the
// cell / tape address widths. The control FSM and the datapath use the same
// widths.
// -----------------------------------------------------------------------------
package bf_pkg;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } tape_state_e;

    localparam int CELL_W      = 8;
    localparam int TAPE_ADDR_W = 8;

endpackage

// File: rtl/bf_tape_arbiter_if.sv
// -----------------------------------------------------------------------------
// bf_tape_arbiter_if
// Bundles the clear handshake, the core and debug request channels and the
// tape RAM port.
//   slave  : the arbiter side (bf_tape_arbiter)
//   master : the requester / RAM side (control FSM, viewer, RAM instance)
// -----------------------------------------------------------------------------
interface bf_tape_arbiter_if
    import bf_pkg::*;
#(
    parameter int ADDR_W = TAPE_ADDR_W,
    parameter int DATA_W = CELL_W
) ();

    logic              clear_req;
    logic              clear_busy;

    logic              core_req;
    logic              core_we;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wdata;
    logic              core_gnt;
    logic              core_rvalid;
    logic [DATA_W-1:0] core_rdata;

    logic              dbg_req;
    logic [ADDR_W-1:0] dbg_addr;
    logic              dbg_gnt;
    logic              dbg_rvalid;
    logic [DATA_W-1:0] dbg_rdata;

    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  clear_req,
        output clear_busy,
        input  core_req, core_we, core_addr, core_wdata,
        output core_gnt, core_rvalid, core_rdata,
        input  dbg_req, dbg_addr,
        output dbg_gnt, dbg_rvalid, dbg_rdata,
        output ram_en, ram_we, ram_addr, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output clear_req,
        input  clear_busy,
        output core_req, core_we, core_addr, core_wdata,
        input  core_gnt, core_rvalid, core_rdata,
        output dbg_req, dbg_addr,
        input  dbg_gnt, dbg_rvalid, dbg_rdata,
        input  ram_en, ram_we, ram_addr, ram_wdata,
        output ram_rdata
    );

endinterface

// File: rtl/bf_tape_clear_seq.sv
// -----------------------------------------------------------------------------
// bf_tape_clear_seq
// Address sequencer for a memory clear: walks 0..DEPTH-1, one address per
// cycle. Comes out of reset already busy, so a clear always follows reset.
// Ports:
//   clk, reset : clock, synchronous active-high reset (restarts the sweep)
//   start      : restart the sweep from address 0
//   busy       : sweep in progress, addr is valid
//   done       : combinational, high during the cycle addr = DEPTH-1
//   addr       : current address to clear
// -----------------------------------------------------------------------------
module bf_tape_clear_seq
    import bf_pkg::*;
#(
    parameter int ADDR_W = TAPE_ADDR_W,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    assign done = busy && (addr == LAST_ADDR);

    always_ff @(posedge clk) begin
        if (reset || start) begin
            busy <= 1'b1;
            addr <= '0;
        end else if (busy) begin
            if (done) begin
                busy <= 1'b0;
            end else begin
                addr <= addr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/bf_tape_arbiter.sv
// -----------------------------------------------------------------------------
// bf_tape_arbiter
// Owns the single-port tape RAM and shares it between the execution core and
// the debug viewer. After reset, or on clear_req, the internal clear engine
// zeroes cells 0..DEPTH-1 (one per cycle) before any request is served.
// In S_RUN the core has fixed priority over debug; the grant and the RAM
// strobe are combinational in the same cycle. Read data returns one cycle
// after the grant together with the matching rvalid, then is held.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : bf_tape_arbiter_if.slave (clear, core, dbg and RAM signals)
// Optional build macro:
//   BF_DBG_STARVE_GUARD_EN : after STARVE_LIMIT consecutive core grants while
//                            dbg waits, dbg wins one cycle.
// -----------------------------------------------------------------------------
module bf_tape_arbiter
    import bf_pkg::*;
#(
    parameter int ADDR_W       = TAPE_ADDR_W,
    parameter int DATA_W       = CELL_W,
    parameter int DEPTH        = 256,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    bf_tape_arbiter_if.slave      bus
);

    if (DEPTH < 1 || DEPTH > (1 << ADDR_W) || STARVE_LIMIT < 0) begin : g_bad_param
        $error("bf_tape_arbiter: DEPTH or STARVE_LIMIT out of range");
    end

    tape_state_e       state;
    logic              run;
    logic              clr_start;
    logic              clr_busy;
    logic              clr_done;
    logic [ADDR_W-1:0] clr_addr;
    logic              core_win;
    logic              dbg_win;
    logic              dbg_force;
    logic              core_vld_p1;
    logic              dbg_vld_p1;
    logic [DATA_W-1:0] core_hold;
    logic [DATA_W-1:0] dbg_hold;

    assign run       = (state == S_RUN);
    assign clr_start = run && bus.clear_req;

    bf_tape_clear_seq #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_clear (
        .clk    (clk),
        .reset  (reset),
        .start  (clr_start),
        .busy   (clr_busy),
        .done   (clr_done),
        .addr   (clr_addr)
    );

`ifdef BF_DBG_STARVE_GUARD_EN
    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_cnt;

    assign dbg_force = bus.core_req && bus.dbg_req &&
                       (starve_cnt == CNT_W'(STARVE_LIMIT));

    // Counts core grants taken while dbg is waiting; any dbg grant or dbg
    // dropping its request ends the streak.
    always_ff @(posedge clk) begin
        if (reset || !run || clr_start) begin
            starve_cnt <= '0;
        end else if (dbg_win || !bus.dbg_req) begin
            starve_cnt <= '0;
        end else if (core_win) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end
`else
    assign dbg_force = 1'b0;
`endif

    assign core_win = run && bus.core_req && !dbg_force;
    assign dbg_win  = run && bus.dbg_req && !core_win;

    assign bus.core_gnt   = core_win;
    assign bus.dbg_gnt    = dbg_win;
    assign bus.clear_busy = clr_busy;

    always_comb begin
        bus.ram_en    = 1'b0;
        bus.ram_we    = 1'b0;
        bus.ram_addr  = '0;
        bus.ram_wdata = '0;
        if (!run) begin
            bus.ram_en   = 1'b1;
            bus.ram_we   = 1'b1;
            bus.ram_addr = clr_addr;
        end else if (core_win) begin
            bus.ram_en    = 1'b1;
            bus.ram_we    = bus.core_we;
            bus.ram_addr  = bus.core_addr;
            bus.ram_wdata = bus.core_we ? bus.core_wdata : '0;
        end else if (dbg_win) begin
            bus.ram_en   = 1'b1;
            bus.ram_addr = bus.dbg_addr;
        end
    end

    // ---- stage p1: RAM output register valid, forward it and hold it ----
    assign bus.core_rvalid = core_vld_p1;
    assign bus.dbg_rvalid  = dbg_vld_p1;
    assign bus.core_rdata  = core_vld_p1 ? bus.ram_rdata : core_hold;
    assign bus.dbg_rdata   = dbg_vld_p1  ? bus.ram_rdata : dbg_hold;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_CLEAR;
            core_vld_p1 <= 1'b0;
            dbg_vld_p1  <= 1'b0;
            core_hold   <= '0;
            dbg_hold    <= '0;
        end else begin
            case (state)
                S_CLEAR: if (clr_done)      state <= S_RUN;
                S_RUN:   if (bus.clear_req) state <= S_CLEAR;
                default:                    state <= S_CLEAR;
            endcase
            // A read granted in the cycle clear_req arrives still returns.
            core_vld_p1 <= core_win && !bus.core_we;
            dbg_vld_p1  <= dbg_win;
            if (core_vld_p1) core_hold <= bus.ram_rdata;
            if (dbg_vld_p1)  dbg_hold  <= bus.ram_rdata;
        end
    end

endmodule
